pipe_hazard_ctrl: RTL



---
 rtl/pipe_hazard_ctrl_pkg.sv | 24 ++
 rtl/pipe_hazard_ctrl_fwd_decode.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: opcodes, forwarding select codes and sequencer states shared by the hazard controller
package pipe_hazard_ctrl_pkg;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_ALU     = 2'b01;
    localparam logic [1:0] FWD_LOAD    = 2'b10;
    localparam logic [1:0] FWD_PC4     = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_fwd_decode.sv
// hazard_fwd_decode: one s2 operand forwarding select from the s3 writer and the s2 source register
module hazard_fwd_decode
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter bit RS2 = 1'b0
) (
    input  logic [31:0] inst_s2,
    input  logic [31:0] inst_s3,
    input  logic        valid_s3,
    output logic [1:0]  fwd_sel
);
    logic [6:0] opc2, opc3;
    logic [4:0] rd, rs;
    logic       writes, used;
    logic [1:0] code;

    // s3 write predicate, result source, and whether s2 actually reads the selected register
    always_comb begin
        opc2    = inst_s2[6:0];
        opc3    = inst_s3[6:0];
        rd      = inst_s3[11:7];
        rs      = RS2 ? inst_s2[24:20] : inst_s2[19:15];
        writes  = valid_s3 && rd != 5'd0 &&
                  (opc3 == OPC_LUI || opc3 == OPC_AUIPC || opc3 == OPC_OP || opc3 == OPC_OP_IMM ||
                   opc3 == OPC_LOAD || opc3 == OPC_JAL || opc3 == OPC_JALR);
        code    = opc3 == OPC_LOAD ? FWD_LOAD :
                  (opc3 == OPC_JAL || opc3 == OPC_JALR) ? FWD_PC4 : FWD_ALU;
        used    = RS2 ? (opc2 == OPC_OP || opc2 == OPC_STORE || opc2 == OPC_BRANCH)
                      : !(opc2 == OPC_LUI || opc2 == OPC_AUIPC || opc2 == OPC_JAL);
        fwd_sel = (writes && used && rs == rd) ? code : FWD_REGFILE;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: boot hold, redirect squash, external freeze and s2 forwarding selects for the 3-stage core
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES  = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_s2,
    input  logic        valid_s2,
    input  logic [31:0] inst_s3,
    input  logic        valid_s3,
    input  logic        redirect_s2,
    input  logic        ext_stall,
    output logic        pc_stall,
    output logic        hold_pipe,
    output logic        kill_s1,
    output logic [1:0]  fwd_sel_a,
    output logic [1:0]  fwd_sel_b,
    output logic        boot_done
);
    localparam logic [2:0] BOOT_LOAD  = 3'(BOOT_CYCLES - 1);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       boot_done_q, boot_done_d;
    logic       redir;
    logic [1:0] sel_a, sel_b;

    hazard_fwd_decode #(.RS2(1'b0)) u_fwd_a (.inst_s2(inst_s2), .inst_s3(inst_s3), .valid_s3(valid_s3), .fwd_sel(sel_a));
    hazard_fwd_decode #(.RS2(1'b1)) u_fwd_b (.inst_s2(inst_s2), .inst_s3(inst_s3), .valid_s3(valid_s3), .fwd_sel(sel_b));

    // sequencer next state and Mealy controls; a stalled redirect is retried because s2 is held
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        boot_done_d = boot_done_q;
        pc_stall    = 1'b0;
        hold_pipe   = 1'b0;
        kill_s1     = 1'b0;
        redir       = redirect_s2 && valid_s2 && !ext_stall;
        case (state_q)
            ST_BOOT: begin
                pc_stall = 1'b1;
                kill_s1  = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d     = ST_RUN;
                    boot_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RUN: begin
                pc_stall  = ext_stall;
                hold_pipe = ext_stall;
                kill_s1   = redir;
                if (redir && FLUSH_CYCLES > 1) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                pc_stall  = ext_stall;
                hold_pipe = ext_stall;
                kill_s1   = !ext_stall;
                if (redir) cnt_d = FLUSH_LOAD;
                else if (!ext_stall) begin
                    if (cnt_q == 3'd0) state_d = ST_RUN;
                    else cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = ST_BOOT;
        endcase
        if (rst) begin
            pc_stall  = 1'b1;
            hold_pipe = 1'b0;
            kill_s1   = 1'b1;
        end
        fwd_sel_a = (rst || state_q == ST_BOOT || !valid_s2) ? FWD_REGFILE : sel_a;
        fwd_sel_b = (rst || state_q == ST_BOOT || !valid_s2) ? FWD_REGFILE : sel_b;
    end

    // state, shared counter and boot flag; reset restarts the full boot hold from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            cnt_q       <= BOOT_LOAD;
            boot_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            boot_done_q <= boot_done_d;
        end
    end

    assign boot_done = boot_done_q;
endmodule
